// File: rtl/beta_bpu_bht.sv
// beta_bpu_bht: fetch-side branch prediction (2-bit BHT + tagged BTB) and
// execute-side resolution with redirect, table training, misaligned-target
// detection and saturating statistics counters.
module beta_bpu_bht #(
    parameter int DATAWIDTH   = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pred_req_i,
    input  logic                 pred_stall_i,
    input  logic [DATAWIDTH-1:0] pred_pc_i,
    output logic                 pred_valid_o,
    output logic                 pred_taken_o,
    output logic [DATAWIDTH-1:0] pred_target_o,
    input  logic                 res_valid_i,
    input  logic                 res_is_jump_i,
    input  logic [DATAWIDTH-1:0] res_pc_i,
    input  logic                 res_taken_i,
    input  logic [DATAWIDTH-1:0] res_target_i,
    input  logic                 res_pred_taken_i,
    input  logic [DATAWIDTH-1:0] res_pred_target_i,
    output logic                 mispredict_o,
    output logic [DATAWIDTH-1:0] redirect_pc_o,
    output logic                 misalig_o,
    output logic [31:0]          stat_branches_o,
    output logic [31:0]          stat_mispred_o
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = DATAWIDTH - BTB_IW - 2;
    localparam logic [DATAWIDTH-1:0] PC_STEP = DATAWIDTH'(4);

    // Table read ports (flattened per-entry state) and BTB payload memories
    logic [2*BHT_ENTRIES-1:0] bht_flat;
    logic [BTB_ENTRIES-1:0]   btb_valid_vec;
    logic [TAG_W-1:0]         btb_tag_mem    [BTB_ENTRIES];
    logic [DATAWIDTH-1:0]     btb_target_mem [BTB_ENTRIES];

    // Fetch-side lookup
    logic [BHT_IW-1:0]    pred_bht_idx;
    logic [BTB_IW-1:0]    pred_btb_idx;
    logic [TAG_W-1:0]     pred_tag;
    logic [1:0]           pred_ctr;
    logic                 pred_hit;
    logic                 pred_taken_next;
    logic [DATAWIDTH-1:0] pred_target_next;
    logic                 pred_valid_reg;
    logic                 pred_taken_reg;
    logic [DATAWIDTH-1:0] pred_target_reg;

    // Execute-side resolution
    logic [BHT_IW-1:0]    res_bht_idx;
    logic [BTB_IW-1:0]    res_btb_idx;
    logic [1:0]           res_ctr;
    logic [1:0]           ctr_next;
    logic                 act_taken;
    logic                 res_misalig;
    logic                 eff_taken;
    logic                 tbl_upd;
    logic                 btb_wr;
    logic                 mis_next;
    logic [DATAWIDTH-1:0] redirect_next;
    logic                 mispredict_reg;
    logic                 misalig_reg;
    logic [DATAWIDTH-1:0] redirect_reg;
    logic [31:0]          stat_br_reg;
    logic [31:0]          stat_mis_reg;

    assign pred_bht_idx = pred_pc_i[BHT_IW+1:2];
    assign pred_btb_idx = pred_pc_i[BTB_IW+1:2];
    assign pred_tag     = pred_pc_i[DATAWIDTH-1:BTB_IW+2];
    assign res_bht_idx  = res_pc_i[BHT_IW+1:2];
    assign res_btb_idx  = res_pc_i[BTB_IW+1:2];

    // Lookup: hit needs a valid, tag-matching BTB entry; taken also needs counter MSB
    always_comb begin
        pred_ctr         = bht_flat[{pred_bht_idx, 1'b0} +: 2];
        pred_hit         = btb_valid_vec[pred_btb_idx] &&
                           (btb_tag_mem[pred_btb_idx] == pred_tag);
        pred_taken_next  = pred_req_i && pred_hit && pred_ctr[1];
        pred_target_next = (pred_hit && pred_ctr[1]) ? btb_target_mem[pred_btb_idx]
                                                     : pred_pc_i + PC_STEP;
    end

    // Resolution: a misaligned taken target is treated as not taken and never trains
    always_comb begin
        act_taken     = res_is_jump_i | res_taken_i;
        res_misalig   = act_taken & (res_target_i[1:0] != 2'b00);
        eff_taken     = act_taken & ~res_misalig;
        tbl_upd       = res_valid_i & ~res_misalig;
        btb_wr        = tbl_upd & eff_taken;
        res_ctr       = bht_flat[{res_bht_idx, 1'b0} +: 2];
        if (res_misalig)
            mis_next = res_pred_taken_i;
        else
            mis_next = (act_taken != res_pred_taken_i) ||
                       (act_taken && (res_target_i != res_pred_target_i));
        redirect_next = eff_taken ? res_target_i : res_pc_i + PC_STEP;
        if (res_is_jump_i)
            ctr_next = 2'b11;
        else if (res_taken_i)
            ctr_next = (res_ctr == 2'b11) ? 2'b11 : res_ctr + 2'd1;
        else
            ctr_next = (res_ctr == 2'b00) ? 2'b00 : res_ctr - 2'd1;
    end

    // Per-entry counters and BTB valid bits, each with its own reset and write enable
    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] ctr_reg;
            // Counter resets weakly not-taken and trains on a matching resolve
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    ctr_reg <= 2'b01;
                else if (tbl_upd && (res_bht_idx == BHT_IW'(gi)))
                    ctr_reg <= ctr_next;
            end
            assign bht_flat[2*gi +: 2] = ctr_reg;
        end
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic valid_reg;
            // Valid bit set by any taken (aligned) resolve into this slot
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    valid_reg <= 1'b0;
                else if (btb_wr && (res_btb_idx == BTB_IW'(gi)))
                    valid_reg <= 1'b1;
            end
            assign btb_valid_vec[gi] = valid_reg;
        end
    endgenerate

    // BTB tag/target payload; no reset needed since valid bits qualify it
    always_ff @(posedge clk_i) begin
        if (!rst_i && btb_wr) begin
            btb_tag_mem[res_btb_idx]    <= res_pc_i[DATAWIDTH-1:BTB_IW+2];
            btb_target_mem[res_btb_idx] <= res_target_i;
        end
    end

    // Prediction outputs register; a stall freezes all of them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
        end else if (!pred_stall_i) begin
            pred_valid_reg  <= pred_req_i;
            pred_taken_reg  <= pred_taken_next;
            pred_target_reg <= pred_target_next;
        end
    end

    // Resolution outputs and saturating statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispredict_reg <= 1'b0;
            misalig_reg    <= 1'b0;
            redirect_reg   <= '0;
            stat_br_reg    <= '0;
            stat_mis_reg   <= '0;
        end else if (res_valid_i) begin
            mispredict_reg <= mis_next;
            misalig_reg    <= res_misalig;
            redirect_reg   <= redirect_next;
            if (stat_br_reg != 32'hFFFF_FFFF)
                stat_br_reg <= stat_br_reg + 32'd1;
            if (mis_next && (stat_mis_reg != 32'hFFFF_FFFF))
                stat_mis_reg <= stat_mis_reg + 32'd1;
        end else begin
            mispredict_reg <= 1'b0;
            misalig_reg    <= 1'b0;
        end
    end

    assign pred_valid_o    = pred_valid_reg;
    assign pred_taken_o    = pred_taken_reg;
    assign pred_target_o   = pred_target_reg;
    assign mispredict_o    = mispredict_reg;
    assign misalig_o       = misalig_reg;
    assign redirect_pc_o   = redirect_reg;
    assign stat_branches_o = stat_br_reg;
    assign stat_mispred_o  = stat_mis_reg;

endmodule

// File: tb/tb_beta_bpu_bht.sv
// Bench for beta_bpu_bht: directed vector table, reset-mid-stream sequence,
// then randomized traffic checked against a behavioural model.
module tb_beta_bpu_bht;

    localparam int BHT_N = 64;
    localparam int BTB_N = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pred_req_i, pred_stall_i;
    logic [31:0] pred_pc_i;
    logic        pred_valid_o, pred_taken_o;
    logic [31:0] pred_target_o;
    logic        res_valid_i, res_is_jump_i, res_taken_i, res_pred_taken_i;
    logic [31:0] res_pc_i, res_target_i, res_pred_target_i;
    logic        mispredict_o, misalig_o;
    logic [31:0] redirect_pc_o, stat_branches_o, stat_mispred_o;

    int n_vec = 0;
    int n_err = 0;

    beta_bpu_bht #(.DATAWIDTH(32), .BHT_ENTRIES(BHT_N), .BTB_ENTRIES(BTB_N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pred_req_i(pred_req_i), .pred_stall_i(pred_stall_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .res_valid_i(res_valid_i), .res_is_jump_i(res_is_jump_i), .res_pc_i(res_pc_i),
        .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .res_pred_taken_i(res_pred_taken_i), .res_pred_target_i(res_pred_target_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .misalig_o(misalig_o),
        .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit req; bit stall; logic [31:0] ppc;
        bit rv; bit jmp; bit tk; logic [31:0] pc; logic [31:0] tgt;
        bit ptk; logic [31:0] ptgt;
        bit e_v; bit e_tk; logic [31:0] e_tg;
        bit e_mis; bit e_ma; logic [31:0] e_red; int e_smis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit req, bit stall, logic [31:0] ppc,
                                bit rv, bit jmp, bit tk, logic [31:0] pc, logic [31:0] tgt,
                                bit ptk, logic [31:0] ptgt,
                                bit e_v, bit e_tk, logic [31:0] e_tg,
                                bit e_mis, bit e_ma, logic [31:0] e_red, int e_smis);
        vec_t v;
        v.req = req; v.stall = stall; v.ppc = ppc;
        v.rv = rv; v.jmp = jmp; v.tk = tk; v.pc = pc; v.tgt = tgt;
        v.ptk = ptk; v.ptgt = ptgt;
        v.e_v = e_v; v.e_tk = e_tk; v.e_tg = e_tg;
        v.e_mis = e_mis; v.e_ma = e_ma; v.e_red = e_red; v.e_smis = e_smis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit req, input bit stall, input logic [31:0] ppc,
                         input bit rv, input bit jmp, input bit tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        pred_req_i = req; pred_stall_i = stall; pred_pc_i = ppc;
        res_valid_i = rv; res_is_jump_i = jmp; res_taken_i = tk; res_pc_i = pc;
        res_target_i = tgt; res_pred_taken_i = ptk; res_pred_target_i = ptgt;
    endtask

    // ---------------- behavioural model ----------------
    int          m_ctr [BHT_N];
    bit          m_bv  [BTB_N];
    logic [31:0] m_btag[BTB_N];
    logic [31:0] m_btgt[BTB_N];
    bit          e_v, e_tk, e_mis, e_ma;
    logic [31:0] e_tg, e_red;
    longint      e_sbr, e_smis;

    task automatic model_reset();
        for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
        for (int i = 0; i < BTB_N; i++) m_bv[i] = 0;
        e_v = 0; e_tk = 0; e_tg = 0; e_mis = 0; e_ma = 0; e_red = 0; e_sbr = 0; e_smis = 0;
    endtask

    task automatic model_step();
        int bi, ti, hi, ri;
        bit at, ma, hit;
        logic [31:0] npc;
        // lookup uses table state before this edge's update
        if (!pred_stall_i) begin
            e_v  = pred_req_i;
            bi   = (pred_pc_i / 4) % BHT_N;
            ti   = (pred_pc_i / 4) % BTB_N;
            hit  = m_bv[ti] && (m_btag[ti] == pred_pc_i / (4 * BTB_N));
            e_tk = pred_req_i && hit && (m_ctr[bi] >= 2);
            npc  = pred_pc_i + 32'd4;
            e_tg = (hit && m_ctr[bi] >= 2) ? m_btgt[ti] : npc;
        end
        if (res_valid_i) begin
            at  = res_is_jump_i || res_taken_i;
            ma  = at && (res_target_i % 4 != 0);
            npc = res_pc_i + 32'd4;
            e_ma = ma;
            if (ma) begin
                e_mis = res_pred_taken_i;
                e_red = npc;
            end else begin
                e_mis = (at != res_pred_taken_i) || (at && res_target_i != res_pred_target_i);
                e_red = at ? res_target_i : npc;
                hi = (res_pc_i / 4) % BHT_N;
                ri = (res_pc_i / 4) % BTB_N;
                if (res_is_jump_i)   m_ctr[hi] = 3;
                else if (at)         m_ctr[hi] = (m_ctr[hi] < 3) ? m_ctr[hi] + 1 : 3;
                else                 m_ctr[hi] = (m_ctr[hi] > 0) ? m_ctr[hi] - 1 : 0;
                if (at) begin
                    m_bv[ri] = 1; m_btag[ri] = res_pc_i / (4 * BTB_N); m_btgt[ri] = res_target_i;
                end
            end
            if (e_sbr < 64'hFFFF_FFFF) e_sbr++;
            if (e_mis && e_smis < 64'hFFFF_FFFF) e_smis++;
        end else begin
            e_mis = 0; e_ma = 0;
        end
    endtask

    initial begin
        int sbr;
        sbr = 0;
        // Directed table (PC 0x204 used for the jump so it does not alias 0x100)
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,0,32'h104,      0,0,0,0));
        tbl.push_back(mk(0,0,0,              1,0,1,32'h100,32'h80,0,0,    0,0,0,            1,0,32'h80,1));
        tbl.push_back(mk(0,0,0,              1,0,1,32'h100,32'h80,0,0,    0,0,0,            1,0,32'h80,2));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,1,32'h80,       0,0,0,2));
        tbl.push_back(mk(0,0,0,              1,0,0,32'h100,32'h80,0,0,    0,0,0,            0,0,32'h104,2));
        tbl.push_back(mk(0,0,0,              1,0,0,32'h100,32'h80,0,0,    0,0,0,            0,0,32'h104,2));
        tbl.push_back(mk(0,0,0,              1,0,0,32'h100,32'h80,0,0,    0,0,0,            0,0,32'h104,2));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,0,32'h104,      0,0,0,2));
        tbl.push_back(mk(0,0,0,              1,0,0,32'h100,32'h80,0,0,    0,0,0,            0,0,32'h104,2));
        tbl.push_back(mk(0,0,0,              1,0,1,32'h100,32'h80,0,0,    0,0,0,            1,0,32'h80,3));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,0,32'h104,      0,0,0,3));
        tbl.push_back(mk(0,0,0,              1,1,0,32'h204,32'h300,1,32'h280, 0,0,0,        1,0,32'h300,4));
        tbl.push_back(mk(1,0,32'h204,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,4));
        tbl.push_back(mk(0,0,0,              1,0,1,32'h100,32'h102,1,32'h80, 0,0,0,         1,1,32'h104,5));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,0,32'h104,      0,0,0,5));
        tbl.push_back(mk(0,0,0,              1,1,0,32'h204,32'h302,1,32'h300, 0,0,0,        1,1,32'h208,6));
        tbl.push_back(mk(1,0,32'h204,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,6));
        tbl.push_back(mk(1,0,32'h100,        1,0,1,32'h100,32'h80,0,0,    1,0,32'h104,      1,0,32'h80,7));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,1,32'h80,       0,0,0,7));
        tbl.push_back(mk(1,0,32'hFFFFFFFC,   1,0,0,32'hFFFFFFFC,32'h0,1,0, 1,0,32'h0,       1,0,32'h0,8));
        tbl.push_back(mk(0,0,0,              1,0,1,32'h100,32'h80,1,32'h80, 0,0,0,          0,0,32'h80,8));
        tbl.push_back(mk(1,0,32'h204,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,8));
        tbl.push_back(mk(1,1,32'h100,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,8));
        tbl.push_back(mk(0,1,32'h100,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,8));
        tbl.push_back(mk(1,1,32'h100,        0,0,0,0,0,0,0,               1,1,32'h300,      0,0,0,8));
        tbl.push_back(mk(0,0,0,              0,0,0,0,0,0,0,               0,0,0,            0,0,0,8));
        tbl.push_back(mk(1,1,32'h204,        0,0,0,0,0,0,0,               0,0,0,            0,0,0,8));
        tbl.push_back(mk(1,0,32'h100,        0,0,0,0,0,0,0,               1,1,32'h80,       0,0,0,8));

        rst_i = 1'b1;
        drive(0,0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset pred_valid", {31'b0, pred_valid_o}, 32'd0);
        chk("reset pred_target", pred_target_o, 32'd0);
        chk("reset stat_branches", stat_branches_o, 32'd0);
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].stall, tbl[i].ppc, tbl[i].rv, tbl[i].jmp, tbl[i].tk,
                  tbl[i].pc, tbl[i].tgt, tbl[i].ptk, tbl[i].ptgt);
            if (tbl[i].rv) sbr++;
            @(posedge clk);
            #1;
            $display("vec %0d: valid=%0b taken=%0b target=%h mis=%0b ma=%0b redirect=%h",
                     i, pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, misalig_o, redirect_pc_o);
            chk($sformatf("v%0d pred_valid", i), {31'b0, pred_valid_o}, {31'b0, tbl[i].e_v});
            if (tbl[i].e_v) begin
                chk($sformatf("v%0d pred_taken", i), {31'b0, pred_taken_o}, {31'b0, tbl[i].e_tk});
                chk($sformatf("v%0d pred_target", i), pred_target_o, tbl[i].e_tg);
            end
            chk($sformatf("v%0d mispredict", i), {31'b0, mispredict_o}, {31'b0, tbl[i].e_mis});
            chk($sformatf("v%0d misalig", i), {31'b0, misalig_o}, {31'b0, tbl[i].e_ma});
            if (tbl[i].rv) chk($sformatf("v%0d redirect", i), redirect_pc_o, tbl[i].e_red);
            chk($sformatf("v%0d stat_mispred", i), stat_mispred_o, 32'(tbl[i].e_smis));
            chk($sformatf("v%0d stat_branches", i), stat_branches_o, 32'(sbr));
        end

        // Reset mid-stream with a lookup and a training resolve in flight
        rst_i = 1'b1;
        drive(1,0,32'h100, 1,0,1,32'h100,32'h80,0,0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        $display("midreset: valid=%0b mis=%0b redirect=%h stats=%0d/%0d",
                 pred_valid_o, mispredict_o, redirect_pc_o, stat_branches_o, stat_mispred_o);
        chk("midreset pred_valid", {31'b0, pred_valid_o}, 32'd0);
        chk("midreset pred_taken", {31'b0, pred_taken_o}, 32'd0);
        chk("midreset mispredict", {31'b0, mispredict_o}, 32'd0);
        chk("midreset redirect", redirect_pc_o, 32'd0);
        chk("midreset stat_branches", stat_branches_o, 32'd0);
        chk("midreset stat_mispred", stat_mispred_o, 32'd0);
        drive(1,0,32'h204, 0,0,0,0,0,0,0);
        @(posedge clk); #1;
        $display("postreset lookup 0x204: taken=%0b target=%h", pred_taken_o, pred_target_o);
        chk("postreset btb cleared taken", {31'b0, pred_taken_o}, 32'd0);
        chk("postreset btb cleared target", pred_target_o, 32'h208);
        drive(0,0,0, 1,0,1,32'h100,32'h80,0,0);
        @(posedge clk); #1;
        $display("postreset resolve: mis=%0b redirect=%h", mispredict_o, redirect_pc_o);
        chk("postreset stat_branches", stat_branches_o, 32'd1);
        drive(1,0,32'h100, 0,0,0,0,0,0,0);
        @(posedge clk); #1;
        $display("postreset lookup 0x100: taken=%0b target=%h", pred_taken_o, pred_target_o);
        chk("postreset counter 01->10 taken", {31'b0, pred_taken_o}, 32'd1);
        chk("postreset counter target", pred_target_o, 32'h80);

        // Randomized traffic against the model
        rst_i = 1'b1;
        drive(0,0,0,0,0,0,0,0,0,0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] bases [3];
            logic [31:0] tgt;
            bases[0] = 32'h0; bases[1] = 32'h1000; bases[2] = 32'hFFFF_FF00;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) tgt = bases[$urandom_range(0, 2)] + 32'(4 * $urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  bases[$urandom_range(0, 2)] + 32'(4 * $urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  bases[$urandom_range(0, 2)] + 32'(4 * $urandom_range(0, 31)), tgt,
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tgt : $urandom);
            rst_i = ($urandom_range(0, 63) == 0);
            if (rst_i) model_reset(); else model_step();
            @(posedge clk); #1;
            rst_i = 1'b0;
            $display("rnd %0d: valid=%0b taken=%0b target=%h mis=%0b ma=%0b redirect=%h stats=%0d/%0d",
                     c, pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, misalig_o,
                     redirect_pc_o, stat_branches_o, stat_mispred_o);
            chk("rnd pred_valid", {31'b0, pred_valid_o}, {31'b0, e_v});
            if (e_v) begin
                chk("rnd pred_taken", {31'b0, pred_taken_o}, {31'b0, e_tk});
                chk("rnd pred_target", pred_target_o, e_tg);
            end
            chk("rnd mispredict", {31'b0, mispredict_o}, {31'b0, e_mis});
            chk("rnd misalig", {31'b0, misalig_o}, {31'b0, e_ma});
            chk("rnd redirect", redirect_pc_o, e_red);
            chk("rnd stat_branches", stat_branches_o, e_sbr[31:0]);
            chk("rnd stat_mispred", stat_mispred_o, e_smis[31:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
